// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR moving-average run/sequence controller.
package fir_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        FILTER,
        WAIT_MA,
        CONVERT,
        WAIT_BCD
    } state_t;

    localparam logic [1:0] PAGE_BLANK = 2'd0;
    localparam logic [1:0] PAGE_HI    = 2'd1;
    localparam logic [1:0] PAGE_MID   = 2'd2;
    localparam logic [1:0] PAGE_LO    = 2'd3;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Control/handshake bundle between the sequencer and the FIR datapath blocks.
interface fir_seq_ctrl_if;

    logic       bcd_busy;
    logic       bcd_done;
    logic       ma_done;
    logic       run;
    logic       lfsr_step;
    logic       ma_step;
    logic       bcd_start;
    logic [1:0] page;
    logic       page_load;
    logic       err;
    logic       ovr;

    modport master (
        input  bcd_busy, bcd_done, ma_done,
        output run, lfsr_step, ma_step, bcd_start, page, page_load, err, ovr
    );

    modport slave (
        output bcd_busy, bcd_done, ma_done,
        input  run, lfsr_step, ma_step, bcd_start, page, page_load, err, ovr
    );

endinterface

// File: rtl/fir_seq_ctrl_debounce.sv
// Button synchronizer and debouncer; emits a 1-cycle pulse on each accepted press (1->0).
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                // Counter value DEBOUNCE_CYC-1 marks the last of DEBOUNCE_CYC differing samples.
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Run/sequence controller: run toggle, slow tick, display page rotation and the
// sample -> filter -> convert handshake sequence with BCD timeout and overrun flags.
module fir_seq_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 25_000_000,
    parameter int unsigned DEBOUNCE_CYC = 500_000,
    parameter int unsigned BCD_TIMEOUT  = 64
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             toggle_btn,
    fir_seq_ctrl_if.master   bus
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned OW = $clog2(BCD_TIMEOUT);

    state_t        state;
    state_t        state_next;
    logic          press;
    logic [TW-1:0] tick_cnt;
    logic [OW-1:0] tmo_cnt;
    logic          tick;
    logic          start_req;
    logic          lfsr_set;
    logic          ma_set;
    logic          start_set;
    logic          err_set;
    logic          ovr_set;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .btn   (toggle_btn),
        .press (press)
    );

    assign tick      = bus.run && (tick_cnt == TW'(TICK_DIV - 1));
    assign start_req = tick && (bus.page == PAGE_LO);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            bus.run       <= 1'b0;
            tick_cnt      <= '0;
            bus.page      <= PAGE_BLANK;
            bus.page_load <= 1'b0;
        end else begin
            bus.run       <= bus.run ^ press;
            bus.page_load <= tick;
            if (!bus.run || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (tick) begin
                bus.page <= bus.page + 2'd1;
            end
        end
    end

    // Pulses are registered on the transition so each lands in the first cycle of its state.
    always_comb begin
        state_next = state;
        lfsr_set   = 1'b0;
        ma_set     = 1'b0;
        start_set  = 1'b0;
        err_set    = 1'b0;
        ovr_set    = start_req && (state != IDLE);
        case (state)
            IDLE: begin
                if (start_req) begin
                    state_next = SAMPLE;
                    lfsr_set   = 1'b1;
                end
            end
            SAMPLE: begin
                state_next = FILTER;
                ma_set     = 1'b1;
            end
            FILTER: begin
                state_next = WAIT_MA;
            end
            WAIT_MA: begin
                // An idle converter is started straight away so bcd_start follows ma_done by one cycle.
                if (bus.ma_done) begin
                    if (bus.bcd_busy) begin
                        state_next = CONVERT;
                    end else begin
                        state_next = WAIT_BCD;
                        start_set  = 1'b1;
                    end
                end
            end
            CONVERT: begin
                if (!bus.bcd_busy) begin
                    state_next = WAIT_BCD;
                    start_set  = 1'b1;
                end
            end
            WAIT_BCD: begin
                if (bus.bcd_done) begin
                    state_next = IDLE;
                end else if (tmo_cnt == OW'(BCD_TIMEOUT - 1)) begin
                    state_next = IDLE;
                    err_set    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            bus.lfsr_step <= 1'b0;
            bus.ma_step   <= 1'b0;
            bus.bcd_start <= 1'b0;
            bus.err       <= 1'b0;
            bus.ovr       <= 1'b0;
        end else begin
            state         <= state_next;
            tmo_cnt       <= (state == WAIT_BCD) ? tmo_cnt + 1'b1 : '0;
            bus.lfsr_step <= lfsr_set;
            bus.ma_step   <= ma_set;
            bus.bcd_start <= start_set;
            bus.err       <= bus.err | err_set;
            bus.ovr       <= bus.ovr | ovr_set;
        end
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl on a fixed cycle timeline measured from the button press.
module tb_fir_seq_ctrl;
    import fir_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    logic toggle_btn;
    int   t;
    int   n_checks;
    int   n_errors;
    int   n_lfsr;
    int   n_ma;
    int   n_bcd;
    int   base_lfsr;
    int   base_ma;
    int   base_bcd;

    fir_seq_ctrl_if bus ();

    fir_seq_ctrl #(
        .TICK_DIV     (8),
        .DEBOUNCE_CYC (4),
        .BCD_TIMEOUT  (6)
    ) dut (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .toggle_btn (toggle_btn),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.lfsr_step) n_lfsr <= n_lfsr + 1;
        if (bus.ma_step)   n_ma   <= n_ma + 1;
        if (bus.bcd_start) n_bcd  <= n_bcd + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic step_to(input int k);
        while (t < k) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_run"},   32'(bus.run), 0);
        check({tag, "_page"},  32'(bus.page), 0);
        check({tag, "_pload"}, 32'(bus.page_load), 0);
        check({tag, "_lfsr"},  32'(bus.lfsr_step), 0);
        check({tag, "_ma"},    32'(bus.ma_step), 0);
        check({tag, "_bstart"},32'(bus.bcd_start), 0);
        check({tag, "_err"},   32'(bus.err), 0);
        check({tag, "_ovr"},   32'(bus.ovr), 0);
        check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        n_lfsr = 0; n_ma = 0; n_bcd = 0;
        t = 0;
        rst_n = 1'b0;
        toggle_btn = 1'b1;
        bus.bcd_busy = 1'b0;
        bus.bcd_done = 1'b0;
        bus.ma_done  = 1'b0;

        step(); step();
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        step(); step();

        // Bounce: never more than 2 consecutive cycles low
        for (int i = 0; i < 20; i++) begin
            toggle_btn = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
        end
        toggle_btn = 1'b1;
        repeat (10) step();
        check("bounce_run", 32'(bus.run), 0);

        // Press at t=0
        t = 0;
        toggle_btn = 1'b0;
        step_to(6);  check("press_run_early", 32'(bus.run), 0);
        step_to(7);  check("press_run_on", 32'(bus.run), 1);
        step_to(10); toggle_btn = 1'b1;
        step_to(15); check("page1", 32'(bus.page), 1);
                     check("page_load_pulse", 32'(bus.page_load), 1);
        step_to(16); check("page_load_end", 32'(bus.page_load), 0);
        step_to(23); check("page2", 32'(bus.page), 2);
        step_to(31); check("page3", 32'(bus.page), 3);
        check("release_ignored", 32'(bus.run), 1);

        // First wrap: full sequence, bcd_done coincides with a tick
        step_to(38);
        base_lfsr = n_lfsr; base_ma = n_ma; base_bcd = n_bcd;
        step_to(39); check("wrap_page0", 32'(bus.page), 0);
                     check("wrap_lfsr", 32'(bus.lfsr_step), 1);
        step_to(40); check("wrap_ma", 32'(bus.ma_step), 1);
                     check("lfsr_single", 32'(bus.lfsr_step), 0);
        step_to(42); bus.ma_done = 1'b1;
        step_to(43); bus.ma_done = 1'b0;
                     check("bcd_start_pulse", 32'(bus.bcd_start), 1);
        step_to(44); check("bcd_start_end", 32'(bus.bcd_start), 0);
        step_to(46); bus.bcd_done = 1'b1;
        step_to(47); bus.bcd_done = 1'b0;
                     check("seq_idle", 32'(dut.state), 32'(IDLE));
                     check("seq_err", 32'(bus.err), 0);
                     check("tick_with_done_page", 32'(bus.page), 1);
        step_to(48); check("seq_lfsr_cnt", 32'(n_lfsr - base_lfsr), 1);
                     check("seq_ma_cnt", 32'(n_ma - base_ma), 1);
                     check("seq_bcd_cnt", 32'(n_bcd - base_bcd), 1);

        // Second wrap: converter busy, then no bcd_done (timeout)
        step_to(71); check("wrap2_lfsr", 32'(bus.lfsr_step), 1);
        step_to(74); bus.ma_done = 1'b1; bus.bcd_busy = 1'b1;
        base_bcd = n_bcd;
        step_to(75); bus.ma_done = 1'b0;
        step_to(80); bus.bcd_busy = 1'b0;
                     check("busy_state", 32'(dut.state), 32'(CONVERT));
        step_to(81); check("busy_no_start", 32'(n_bcd - base_bcd), 0);
                     check("busy_start", 32'(bus.bcd_start), 1);
        step_to(83); check("busy_one_start", 32'(n_bcd - base_bcd), 1);
        step_to(86); check("tmo_err_early", 32'(bus.err), 0);
        step_to(87); check("tmo_err", 32'(bus.err), 1);
                     check("tmo_idle", 32'(dut.state), 32'(IDLE));

        // Third wrap starts normally, then ma_done withheld across the fourth
        step_to(103); check("wrap3_lfsr", 32'(bus.lfsr_step), 1);
                      check("wrap3_ovr", 32'(bus.ovr), 0);
        step_to(104); base_lfsr = n_lfsr;
        step_to(134); check("ovr_before", 32'(bus.ovr), 0);
        step_to(135); check("ovr_set", 32'(bus.ovr), 1);
                      check("ovr_page_adv", 32'(bus.page), 0);
        step_to(136); bus.ma_done = 1'b1;
                      check("ovr_no_lfsr", 32'(n_lfsr - base_lfsr), 0);
        step_to(137); bus.ma_done = 1'b0;
                      check("late_bcd_start", 32'(bus.bcd_start), 1);
        step_to(138); check("pre_rst_state", 32'(dut.state), 32'(WAIT_BCD));
                      check("pre_rst_run", 32'(bus.run), 1);

        // Asynchronous reset mid-WAIT_BCD
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk) rst_n = 1'b1;
        step(); step();
        check("post_rst_run", 32'(bus.run), 0);
        check("post_rst_page", 32'(bus.page), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
